fp_cvt_narrow_pipe: RTL and testbench

Parametrised, pipelined floating-point narrowing converter: takes one IEEE-754 binary value of a wide format and produces the correctly rounded value in a narrower format, plus RISC-V exception flags. It is the successor to the combinational double-to-single converter in the D-extension ALU. Over that converter it adds generic format widths, all five RISC-V rounding modes, correct subnormal/overflow/NaN handling and a valid/ready pipeline with backpressure. It sits between the FP operand read stage and the FP result writeback arbiter.

---
 rtl/fp_cvt_narrow_pipe_if.sv | 24 ++
 rtl/fp_cvt_narrow_pipe.sv | 130 +++++++++++++
 tb/tb_fp_cvt_narrow_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_cvt_narrow_pipe_if.sv
// fp_cvt_narrow_pipe_if: operand/result handshake bundle for the narrowing converter
interface fp_cvt_narrow_pipe_if #(
  parameter int IN_EW = 11,
  parameter int IN_MW = 52,
  parameter int OUT_EW = 8,
  parameter int OUT_MW = 23
);
  logic in_valid;
  logic in_ready;
  logic [IN_EW+IN_MW:0] in_data;
  logic [2:0] in_rm;
  logic out_valid;
  logic out_ready;
  logic [OUT_EW+OUT_MW:0] out_data;
  logic [4:0] out_flags;
  modport slave (
    input in_valid, in_data, in_rm, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
  modport master (
    output in_valid, in_data, in_rm, out_ready,
    input in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp_cvt_narrow_pipe.sv
// fp_cvt_narrow_pipe: 3-stage IEEE-754 narrowing converter with RISC-V rounding and flags
module fp_cvt_narrow_pipe #(
  parameter int IN_EW = 11,
  parameter int IN_MW = 52,
  parameter int OUT_EW = 8,
  parameter int OUT_MW = 23
) (
  input logic clk,
  input logic rst_n,
  fp_cvt_narrow_pipe_if.slave bus
);
  localparam int EW = IN_EW + 2;
  localparam int W = IN_MW + 3;
  localparam logic signed [EW-1:0] BIAS_IN = EW'(2**(IN_EW-1)-1);
  localparam logic signed [EW-1:0] E_SUB = EW'(2-2**(IN_EW-1));
  localparam logic signed [EW-1:0] BIAS_OUT = EW'(2**(OUT_EW-1)-1);
  localparam logic signed [EW-1:0] MIN_E = EW'(2-2**(OUT_EW-1));
  localparam logic signed [EW-1:0] SH_MAX = EW'(OUT_MW+3);
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [OUT_EW+OUT_MW:0] QNAN = {1'b0, {OUT_EW{1'b1}}, 1'b1, {(OUT_MW-1){1'b0}}};
  localparam logic [OUT_EW+OUT_MW-1:0] INF = {{OUT_EW{1'b1}}, {OUT_MW{1'b0}}};
  localparam logic [OUT_EW+OUT_MW-1:0] MAXF = {{(OUT_EW-1){1'b1}}, 1'b0, {OUT_MW{1'b1}}};

  logic en;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  logic sgn_in;
  logic [IN_EW-1:0] exp_in;
  logic [IN_MW-1:0] frac_in;
  assign {sgn_in, exp_in, frac_in} = bus.in_data;

  logic v1, s1, inf1, nan1, snan1;
  logic signed [EW-1:0] e1;
  logic [IN_MW:0] m1;
  logic [2:0] rm1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, s1, inf1, nan1, snan1, m1, rm1} <= '0;
      e1 <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      s1 <= sgn_in;
      inf1 <= &exp_in && frac_in == '0;
      nan1 <= &exp_in && frac_in != '0;
      snan1 <= &exp_in && frac_in != '0 && !frac_in[IN_MW-1];
      e1 <= exp_in == '0 ? E_SUB : $signed(EW'(exp_in)) - BIAS_IN;
      m1 <= {|exp_in, frac_in};
      rm1 <= bus.in_rm > RMM ? RNE : bus.in_rm;
    end

  logic tiny, ovf, lost;
  logic signed [EW-1:0] diff;
  logic [EW-1:0] sh;
  logic [W-1:0] w, sv;

  // Shifts past OUT_MW+2 are clamped: every kept bit is already zero, the rest lands in sticky.
  always_comb begin
    ovf = e1 > BIAS_OUT;
    tiny = e1 < MIN_E;
    diff = MIN_E - e1;
    sh = !tiny ? '0 : (diff > SH_MAX ? SH_MAX : diff);
    w = {m1, 2'b00};
    sv = w >> sh;
    lost = |(w & ~({W{1'b1}} << sh));
  end

  logic v2, s2, inf2, nan2, snan2, ovf2, tiny2, g2, r2, st2;
  logic [OUT_EW-1:0] x2;
  logic [OUT_MW:0] m2;
  logic [2:0] rm2;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v2, s2, inf2, nan2, snan2, ovf2, tiny2, g2, r2, st2, x2, m2, rm2} <= '0;
    end else if (en) begin
      v2 <= v1;
      s2 <= s1;
      inf2 <= inf1;
      nan2 <= nan1;
      snan2 <= snan1;
      ovf2 <= ovf;
      tiny2 <= tiny;
      x2 <= tiny ? '0 : OUT_EW'(e1 + BIAS_OUT);
      m2 <= sv[W-1 -: OUT_MW+1];
      g2 <= sv[W-2-OUT_MW];
      r2 <= sv[W-3-OUT_MW];
      st2 <= |sv[W-4-OUT_MW:0] | lost;
      rm2 <= rm1;
    end

  logic rs, inc, of, nx, uf, to_inf;
  logic [OUT_MW+1:0] sum;
  logic [OUT_EW:0] ex;
  logic [OUT_MW-1:0] frac;
  logic [OUT_EW+OUT_MW:0] res;
  logic [4:0] flg;

  // A subnormal (x2 == 0) that rounds into the hidden bit becomes the minimum normal.
  always_comb begin
    rs = r2 | st2;
    inc = rm2 == RTZ ? 1'b0 :
          rm2 == RDN ? s2 & (g2 | rs) :
          rm2 == RUP ? !s2 & (g2 | rs) :
          rm2 == RMM ? g2 : g2 & (rs | m2[0]);
    sum = {1'b0, m2} + {{(OUT_MW+1){1'b0}}, inc};
    ex = x2 == '0 ? {{OUT_EW{1'b0}}, sum[OUT_MW]} : {1'b0, x2} + {{OUT_EW{1'b0}}, sum[OUT_MW+1]};
    frac = sum[OUT_MW+1] ? sum[OUT_MW:1] : sum[OUT_MW-1:0];
    of = ovf2 || ex == {1'b0, {OUT_EW{1'b1}}};
    nx = g2 | rs | of;
    uf = tiny2 & nx;
    to_inf = rm2 == RNE || rm2 == RMM || (rm2 == RDN && s2) || (rm2 == RUP && !s2);
    res = nan2 ? QNAN :
          inf2 || (of && to_inf) ? {s2, INF} :
          of ? {s2, MAXF} : {s2, ex[OUT_EW-1:0], frac};
    flg = nan2 ? {snan2, 4'b0000} : inf2 ? 5'b00000 : {2'b00, of, uf, nx};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_flags <= '0;
    end else if (en) begin
      bus.out_valid <= v2;
      bus.out_data <= res;
      bus.out_flags <= flg;
    end
endmodule

// File: tb/tb_fp_cvt_narrow_pipe.sv
// tb_fp_cvt_narrow_pipe: directed double-to-single vectors, backpressure stream and async reset
module tb_fp_cvt_narrow_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  fp_cvt_narrow_pipe_if b ();
  fp_cvt_narrow_pipe dut (.clk(clk), .rst_n(rst_n), .bus(b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [63:0] d, input logic [2:0] rm,
                      input logic [31:0] q, input logic [4:0] f);
    int lat;
    @(negedge clk);
    b.out_ready = 1'b1;
    b.in_valid = 1'b1;
    b.in_data = d;
    b.in_rm = rm;
    #1 check({tag, "/rdy"}, 64'(b.in_ready), 64'd1);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    lat = 1;
    while (!b.out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'd3);
    check({tag, "/data"}, 64'(b.out_data), 64'(q));
    check({tag, "/flags"}, 64'(b.out_flags), 64'(f));
  endtask

  logic [63:0] sd[6];
  logic [2:0] srm[6];
  logic [31:0] sq[6];

  initial begin
    int sent, rcv, stall, stale;
    b.in_valid = 1'b0;
    b.in_data = '0;
    b.in_rm = 3'd0;
    b.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/valid", 64'(b.out_valid), 64'd0);
    check("rst/data", 64'(b.out_data), 64'd0);
    check("rst/flags", 64'(b.out_flags), 64'd0);
    rst_n = 1'b1;
    #1 check("rst/in_ready", 64'(b.in_ready), 64'd1);

    run1("one", 64'h3FF0000000000000, 3'd0, 32'h3F800000, 5'h00);
    run1("m2", 64'hC000000000000000, 3'd0, 32'hC0000000, 5'h00);
    run1("half_rne", 64'h3FF0000010000000, 3'd0, 32'h3F800000, 5'h01);
    run1("half_rup", 64'h3FF0000010000000, 3'd3, 32'h3F800001, 5'h01);
    run1("half_rtz", 64'h3FF0000010000000, 3'd1, 32'h3F800000, 5'h01);
    run1("half_rdn_neg", 64'hBFF0000010000000, 3'd2, 32'hBF800001, 5'h01);
    run1("ovf_rne", 64'h47F0000000000000, 3'd0, 32'h7F800000, 5'h05);
    run1("ovf_rtz", 64'h47F0000000000000, 3'd1, 32'h7F7FFFFF, 5'h05);
    run1("ovf_rup_neg", 64'hC7F0000000000000, 3'd3, 32'hFF7FFFFF, 5'h05);
    run1("ovf_rdn_neg", 64'hC7F0000000000000, 3'd2, 32'hFF800000, 5'h05);
    run1("ovf_rmm", 64'h47F0000000000000, 3'd4, 32'h7F800000, 5'h05);
    run1("carry_ovf_rne", 64'h47EFFFFFF0000000, 3'd0, 32'h7F800000, 5'h05);
    run1("carry_rtz", 64'h47EFFFFFF0000000, 3'd1, 32'h7F7FFFFF, 5'h01);
    run1("sub149", 64'h36A0000000000000, 3'd0, 32'h00000001, 5'h00);
    run1("sub150_rne", 64'h3690000000000000, 3'd0, 32'h00000000, 5'h03);
    run1("sub150_rup", 64'h3690000000000000, 3'd3, 32'h00000001, 5'h03);
    run1("dsub_rdn", 64'h0000000000000001, 3'd2, 32'h00000000, 5'h03);
    run1("snan", 64'h7FF0000000000001, 3'd0, 32'h7FC00000, 5'h10);
    run1("qnan_neg", 64'hFFF8000000000000, 3'd0, 32'h7FC00000, 5'h00);
    run1("ninf", 64'hFFF0000000000000, 3'd0, 32'hFF800000, 5'h00);
    run1("nzero", 64'h8000000000000000, 3'd0, 32'h80000000, 5'h00);

    sd = '{64'h3FF0000010000000, 64'h3FF0000010000000, 64'hBFF0000010000000,
           64'h3FF0000010000000, 64'h3FF0000010000000, 64'h3FF0000010000000};
    srm = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd4, 3'd7};
    sq = '{32'h3F800000, 32'h3F800001, 32'hBF800001, 32'h3F800000, 32'h3F800001, 32'h3F800000};
    repeat (3) @(negedge clk);
    sent = 0;
    rcv = 0;
    stall = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      b.out_ready = !(c >= 3 && c < 8);
      b.in_valid = sent < 6;
      if (sent < 6) begin
        b.in_data = sd[sent];
        b.in_rm = srm[sent];
      end
      #1;
      if (!b.in_ready) stall++;
      if (b.out_valid) begin
        if (rcv < 6) begin
          check($sformatf("strm%0d/data", rcv), 64'(b.out_data), 64'(sq[rcv]));
          check($sformatf("strm%0d/flags", rcv), 64'(b.out_flags), 64'h01);
        end else check("strm/extra", 64'(b.out_valid), 64'd0);
        if (b.out_ready) rcv++;
      end
      if (b.in_valid && b.in_ready) sent++;
    end
    b.in_valid = 1'b0;
    check("strm/stall_cycles", 64'(stall), 64'd5);
    check("strm/count", 64'(rcv), 64'd6);

    @(negedge clk);
    b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.in_valid = 1'b1;
      b.in_data = 64'h3FF0000000000000;
      b.in_rm = 3'd0;
      @(negedge clk);
    end
    b.in_valid = 1'b0;
    #1 check("mid/valid_before", 64'(b.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("mid/valid_async", 64'(b.out_valid), 64'd0);
    check("mid/data_async", 64'(b.out_data), 64'd0);
    check("mid/flags_async", 64'(b.out_flags), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid/in_ready", 64'(b.in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 if (b.out_valid) stale++;
    end
    check("mid/stale", 64'(stale), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
